// File: rtl/uart_pkg.sv
// Shared definitions for the uart_loopback transmit and receive paths:
// state encoding, parity mode codes, default clocking and bit-period derivation.
package uart_pkg;

  localparam int DEF_CLK_FREQ_HZ = 25_000_000;
  localparam int DEF_BAUD        = 9600;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  function automatic int calc_bps_para(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction

  // Odd parity makes the total count of ones (data plus parity) odd.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_EVEN) ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..BPS_PARA-1 while enabled and flags the last
// cycle of each period. The receiver reuses it for mid-bit sampling.
module uart_bit_timer #(
  parameter int BPS_PARA = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (BPS_PARA > 1) ? $clog2(BPS_PARA) : 1;
  localparam logic [CW-1:0] LAST = CW'(BPS_PARA - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : (cnt_q + CW'(1'b1));
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: takes a byte on a valid/ready handshake and sends it LSB
// first as 8N1/8E1/8O1 with one or two stop bits, timed by an internal counter.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int BAUD        = DEF_BAUD,
  parameter int PARITY      = PAR_NONE,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int   BPS_PARA  = calc_bps_para(CLK_FREQ_HZ, BAUD);
  localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (BPS_PARA < 2) begin : g_bad_bps
    $error("uart_tx: CLK_FREQ_HZ/BAUD must be at least 2");
  end

  uart_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_idx_q, stop_idx_d;
  logic        txd_q, txd_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick;

  uart_bit_timer #(
    .BPS_PARA(BPS_PARA)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .en  (state_q != ST_IDLE),
    .clr (state_q == ST_IDLE),
    .tick(tick)
  );

  // txd is computed one cycle ahead so the line is always driven from a flop.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    data_d     = data_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    txd_d      = txd_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid && ready_q) begin
          state_d    = ST_START;
          shift_d    = tx_data;
          data_d     = tx_data;
          bit_idx_d  = 3'd0;
          stop_idx_d = 1'b0;
          txd_d      = 1'b0;
        end else begin
          txd_d = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          txd_d   = shift_q[0];
        end else begin
          txd_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q != 3'd7) begin
            txd_d = shift_q[1];
          end else if (PARITY != PAR_NONE) begin
            state_d = ST_PAR;
            txd_d   = parity_bit(data_q, PARITY);
          end else begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end
        end else begin
          txd_d = txd_q;
        end
      end
      ST_PAR: begin
        if (tick) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end else begin
          txd_d = txd_q;
        end
      end
      ST_STOP: begin
        txd_d = 1'b1;
        if (tick && (stop_idx_q == LAST_STOP)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (tick) begin
          stop_idx_d = 1'b1;
        end else begin
          stop_idx_d = stop_idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      txd_q      <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      txd_q      <= txd_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign txd      = txd_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: five parameterisations, bytes queued on
// handshake and compared cycle by cycle against the expected serial frame.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_s [5];
  logic [4:0] valid_v = 5'b0;
  logic [4:0] ready_v, txd_v, busy_v, done_v;

  int bps_t  [5] = '{10, 10, 10, 10, 2604};
  int par_t  [5] = '{0, 2, 1, 0, 0};
  int stop_t [5] = '{1, 1, 1, 2, 1};

  typedef struct {
    int         d;
    logic [7:0] b;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt [5] = '{0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(1)) u_n1 (
    .clk(clk), .rst(rst), .tx_data(data_s[0]), .tx_valid(valid_v[0]), .tx_ready(ready_v[0]),
    .txd(txd_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .PARITY(2), .STOP_BITS(1)) u_e1 (
    .clk(clk), .rst(rst), .tx_data(data_s[1]), .tx_valid(valid_v[1]), .tx_ready(ready_v[1]),
    .txd(txd_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .PARITY(1), .STOP_BITS(1)) u_o1 (
    .clk(clk), .rst(rst), .tx_data(data_s[2]), .tx_valid(valid_v[2]), .tx_ready(ready_v[2]),
    .txd(txd_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
  uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .PARITY(0), .STOP_BITS(2)) u_n2 (
    .clk(clk), .rst(rst), .tx_data(data_s[3]), .tx_valid(valid_v[3]), .tx_ready(ready_v[3]),
    .txd(txd_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));
  uart_tx u_def (
    .clk(clk), .rst(rst), .tx_data(data_s[4]), .tx_valid(valid_v[4]), .tx_ready(ready_v[4]),
    .txd(txd_v[4]), .tx_busy(busy_v[4]), .tx_done(done_v[4]));

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (done_v[i] === 1'b1) done_cnt[i]++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] frame_bits(input logic [7:0] b, input int par);
    logic [11:0] f;
    f    = 12'hFFF;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
    if (par == 2) f[9] = ^b;
    else if (par == 1) f[9] = ~^b;
    return f;
  endfunction

  // Returns just after the handshake edge; valid stays high when hold is set.
  task automatic send(input int d, input logic [7:0] b, input bit hold);
    int   k;
    exp_t e;
    k = 0;
    @(negedge clk);
    data_s[d]  = b;
    valid_v[d] = 1'b1;
    while (ready_v[d] !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq($sformatf("d%0d handshake_wait", d), (k < 200), 1);
    @(posedge clk);
    #1;
    if (!hold) valid_v[d] = 1'b0;
    e.d = d;
    e.b = b;
    sb_q.push_back(e);
  endtask

  // Called just after a handshake edge; ends on the tx_done cycle.
  task automatic expect_frame(input int d);
    exp_t        e;
    int          wait_n, bps, nb;
    logic [11:0] bits;
    bps    = bps_t[d];
    wait_n = 1;
    @(negedge clk);
    while (txd_v[d] !== 1'b0 && wait_n < 5) begin
      @(negedge clk);
      wait_n++;
    end
    check_eq($sformatf("d%0d start_latency", d), wait_n, 1);
    if (sb_q.size() == 0) begin
      check_eq($sformatf("d%0d sb_underflow", d), sb_q.size(), 1);
      return;
    end
    e = sb_q.pop_front();
    check_eq($sformatf("d%0d sb_dut", d), e.d, d);
    bits = frame_bits(e.b, par_t[d]);
    nb   = 9 + ((par_t[d] != 0) ? 1 : 0) + stop_t[d];
    for (int c = 0; c < nb * bps; c++) begin
      if (c > 0) @(negedge clk);
      check_eq($sformatf("d%0d b%02h txd c%0d", d, e.b, c), txd_v[d], bits[c / bps]);
      check_eq($sformatf("d%0d busy c%0d", d, c), busy_v[d], 1);
      check_eq($sformatf("d%0d ready c%0d", d, c), ready_v[d], 0);
      check_eq($sformatf("d%0d done c%0d", d, c), done_v[d], 0);
    end
    @(negedge clk);
    check_eq($sformatf("d%0d done_end", d), done_v[d], 1);
    check_eq($sformatf("d%0d txd_end", d), txd_v[d], 1);
    check_eq($sformatf("d%0d busy_end", d), busy_v[d], 0);
    check_eq($sformatf("d%0d ready_end", d), ready_v[d], 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int i = 0; i < 5; i++) data_s[i] = 8'h00;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("d%0d rst_txd", i), txd_v[i], 1);
      check_eq($sformatf("d%0d rst_ready", i), ready_v[i], 1);
      check_eq($sformatf("d%0d rst_busy", i), busy_v[i], 0);
      check_eq($sformatf("d%0d rst_done", i), done_v[i], 0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single 8N1 byte
    send(0, 8'hA5, 1'b0);
    expect_frame(0);
    @(negedge clk);
    check_eq("single_done_pulse_len", done_v[0], 0);

    // back-to-back with valid held: one idle cycle between frames
    c0 = done_cnt[0];
    send(0, 8'h00, 1'b1);
    data_s[0] = 8'hFF;
    begin
      exp_t e2;
      e2.d = 0;
      e2.b = 8'hFF;
      sb_q.push_back(e2);
    end
    expect_frame(0);
    @(posedge clk);
    #1 valid_v[0] = 1'b0;
    expect_frame(0);
    repeat (3) @(negedge clk);
    check_eq("b2b_done_count", done_cnt[0] - c0, 2);
    check_eq("b2b_idle_busy", busy_v[0], 0);

    // valid pulsed mid-frame is ignored
    send(0, 8'hC3, 1'b0);
    fork
      expect_frame(0);
      begin
        repeat (35) @(negedge clk);
        data_s[0]  = 8'h55;
        valid_v[0] = 1'b1;
        check_eq("busy_ignore_ready0", ready_v[0], 0);
        @(negedge clk);
        check_eq("busy_ignore_ready1", ready_v[0], 0);
        valid_v[0] = 1'b0;
      end
    join
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check_eq($sformatf("busy_ignore_idle_txd%0d", i), txd_v[0], 1);
      check_eq($sformatf("busy_ignore_idle_busy%0d", i), busy_v[0], 0);
    end
    check_eq("busy_ignore_sb_left", sb_q.size(), 0);

    // parity modes and two stop bits
    send(1, 8'h07, 1'b0);
    expect_frame(1);
    send(2, 8'h07, 1'b0);
    expect_frame(2);
    send(3, 8'h3C, 1'b0);
    expect_frame(3);

    // reset during data bit 3 (cycles 41-50)
    c0 = done_cnt[0];
    send(0, 8'hF0, 1'b0);
    repeat (45) @(negedge clk);
    check_eq("pre_rst_txd", txd_v[0], 0);
    check_eq("pre_rst_busy", busy_v[0], 1);
    rst = 1'b1;
    #1;
    check_eq("rst_async_txd", txd_v[0], 1);
    check_eq("rst_async_busy", busy_v[0], 0);
    check_eq("rst_async_ready", ready_v[0], 1);
    check_eq("rst_async_done", done_v[0], 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq($sformatf("post_rst_txd%0d", i), txd_v[0], 1);
      check_eq($sformatf("post_rst_done%0d", i), done_v[0], 0);
    end
    check_eq("rst_no_done", done_cnt[0] - c0, 0);
    send(0, 8'h81, 1'b0);
    expect_frame(0);

    // default parameters, 2604 cycles per bit
    send(4, 8'h55, 1'b0);
    expect_frame(4);
    @(negedge clk);
    check_eq("def_done_pulse_len", done_v[4], 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
